// File: rtl/sdram_probe_clear_ctrl.sv
// Post-lock SDRAM sequencer: probes module size through address aliasing, then clears the detected range.
// Build option SDRAM_CLR_VERIFY_EN adds a read-back verify pass that counts mismatches in err_cnt.
module sdram_probe_clear_ctrl #(
    parameter int          ADDR_W    = 27,
    parameter int          CLR_WORDS = 2**27,
    parameter logic [15:0] CLR_VALUE = 16'h0,
    parameter int          TMO_CYC   = 4096
) (
    input  logic              clk_sys,
    input  logic              RESET,
    input  logic              start,
    input  logic              sdram_ready,
    input  logic [15:0]       sdram_dout,
    output logic [ADDR_W-1:0] sdram_addr,
    output logic [15:0]       sdram_din,
    output logic              sdram_we,
    output logic              sdram_rd,
    output logic [15:0]       cfg,
    output logic              clr_busy,
    output logic              clr_done,
    output logic [15:0]       err_cnt
);
    localparam int CNT_W = ADDR_W + 1;
    localparam int TMO_W = $clog2(TMO_CYC + 1);
    localparam logic [CNT_W-1:0] SZ_32M   = CNT_W'(32'h200_0000);
    localparam logic [CNT_W-1:0] SZ_64M   = CNT_W'(32'h400_0000);
    localparam logic [CNT_W-1:0] SZ_128M  = CNT_W'(32'h800_0000);
    localparam logic [CNT_W-1:0] CLR_LIM  = CNT_W'(CLR_WORDS);
    localparam logic [ADDR_W-1:0] A_PR3   = ADDR_W'(32'h400_0000);
    localparam logic [ADDR_W-1:0] A_PR2   = ADDR_W'(32'h200_0000);
    localparam logic [ADDR_W-1:0] A_PRM   = ADDR_W'(32'h100_0000);

    typedef enum logic [3:0] {
        ST_IDLE, ST_PW3, ST_PW2, ST_PW0, ST_PWM, ST_PR3, ST_PR2, ST_PR0, ST_SIZE, ST_CLR,
`ifdef SDRAM_CLR_VERIFY_EN
        ST_VFY,
`endif
        ST_WAIT1, ST_WAITR, ST_DONE
    } state_t;

    state_t           state_q, state_d, cmd_q, cmd_d, cmd_sel;
    logic [15:0]      cfg_q, cfg_d;
    logic             busy_q, busy_d, done_q, done_d;
    logic [CNT_W-1:0] addr_q, addr_d, lim_m1_q, lim_m1_d, lim;
    logic [TMO_W-1:0] tmo_q, tmo_d;
`ifdef SDRAM_CLR_VERIFY_EN
    logic [15:0]      err_q, err_d;
    assign err_cnt = err_q;
`else
    assign err_cnt = 16'h0;
`endif

    assign cfg      = cfg_q;
    assign clr_busy = busy_q;
    assign clr_done = done_q;

    always_comb begin
        lim = cfg_q[2] ? SZ_128M : cfg_q[1] ? SZ_64M : cfg_q[0] ? SZ_32M : '0;
        if (lim > CLR_LIM)
            lim = CLR_LIM;
    end

    // Address/data follow the issuing command through both wait states so they stay stable.
    always_comb begin
        cmd_sel    = (state_q == ST_WAIT1 || state_q == ST_WAITR) ? cmd_q : state_q;
        sdram_addr = '0;
        sdram_din  = 16'h0;
        case (cmd_sel)
            ST_PW3: begin sdram_addr = A_PR3; sdram_din = 16'd3128;  end
            ST_PW2: begin sdram_addr = A_PR2; sdram_din = 16'd2064;  end
            ST_PW0: begin sdram_addr = '0;    sdram_din = 16'd1032;  end
            ST_PWM: begin sdram_addr = A_PRM; sdram_din = 16'd12345; end
            ST_PR3: sdram_addr = A_PR3;
            ST_PR2: sdram_addr = A_PR2;
            ST_CLR: begin sdram_addr = addr_q[ADDR_W-1:0]; sdram_din = CLR_VALUE; end
`ifdef SDRAM_CLR_VERIFY_EN
            ST_VFY: sdram_addr = addr_q[ADDR_W-1:0];
`endif
            default: ;
        endcase
    end

    always_comb begin
        state_d  = state_q;
        cmd_d    = cmd_q;
        cfg_d    = cfg_q;
        busy_d   = busy_q;
        done_d   = done_q;
        addr_d   = addr_q;
        lim_m1_d = lim_m1_q;
        tmo_d    = tmo_q;
`ifdef SDRAM_CLR_VERIFY_EN
        err_d    = err_q;
`endif
        sdram_we = 1'b0;
        sdram_rd = 1'b0;
        case (state_q)
            ST_IDLE: if (start || sdram_ready) state_d = ST_PW3;
            ST_PW3, ST_PW2, ST_PW0, ST_PWM, ST_CLR: if (sdram_ready) begin
                sdram_we = 1'b1;
                cmd_d    = state_q;
                state_d  = ST_WAIT1;
            end
            ST_PR3, ST_PR2, ST_PR0: if (sdram_ready) begin
                sdram_rd = 1'b1;
                cmd_d    = state_q;
                state_d  = ST_WAIT1;
            end
`ifdef SDRAM_CLR_VERIFY_EN
            ST_VFY: if (sdram_ready) begin
                sdram_rd = 1'b1;
                cmd_d    = state_q;
                state_d  = ST_WAIT1;
            end
`endif
            ST_WAIT1: begin
                tmo_d   = TMO_W'(TMO_CYC - 1);
                state_d = ST_WAITR;
            end
            ST_WAITR: begin
                if (sdram_ready) begin
                    case (cmd_q)
                        ST_PW3: state_d = ST_PW2;
                        ST_PW2: state_d = ST_PW0;
                        ST_PW0: state_d = ST_PWM;
                        ST_PWM: state_d = ST_PR3;
                        ST_PR3: begin cfg_d[2] = (sdram_dout == 16'd3128); state_d = ST_PR2; end
                        ST_PR2: begin cfg_d[1] = (sdram_dout == 16'd2064); state_d = ST_PR0; end
                        ST_PR0: begin
                            cfg_d[0]  = (sdram_dout == 16'd1032);
                            cfg_d[15] = 1'b1;
                            state_d   = ST_SIZE;
                        end
                        ST_CLR: begin
                            if (addr_q == lim_m1_q) begin
                                busy_d = 1'b0;
`ifdef SDRAM_CLR_VERIFY_EN
                                addr_d  = '0;
                                state_d = ST_VFY;
`else
                                done_d  = 1'b1;
                                state_d = ST_DONE;
`endif
                            end else begin
                                addr_d  = addr_q + CNT_W'(1);
                                state_d = ST_CLR;
                            end
                        end
`ifdef SDRAM_CLR_VERIFY_EN
                        ST_VFY: begin
                            if (sdram_dout != CLR_VALUE && err_q != 16'hFFFF)
                                err_d = err_q + 16'h1;
                            if (addr_q == lim_m1_q) begin
                                done_d  = 1'b1;
                                state_d = ST_DONE;
                            end else begin
                                addr_d  = addr_q + CNT_W'(1);
                                state_d = ST_VFY;
                            end
                        end
`endif
                        default: state_d = ST_DONE;
                    endcase
                end else if (tmo_q == '0) begin
                    cfg_d[15:14] = 2'b11;
                    busy_d       = 1'b0;
                    done_d       = 1'b1;
                    state_d      = ST_DONE;
                end else begin
                    tmo_d = tmo_q - TMO_W'(1);
                end
            end
            ST_SIZE: begin
                if (lim == '0) begin
                    done_d  = 1'b1;
                    state_d = ST_DONE;
                end else begin
                    lim_m1_d = lim - CNT_W'(1);
                    addr_d   = '0;
                    busy_d   = 1'b1;
                    state_d  = ST_CLR;
                end
            end
            ST_DONE: if (start) begin
                cfg_d   = 16'h0;
                done_d  = 1'b0;
`ifdef SDRAM_CLR_VERIFY_EN
                err_d   = 16'h0;
`endif
                state_d = ST_PW3;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk_sys) begin
        if (RESET) begin
            state_q  <= ST_IDLE;
            cmd_q    <= ST_IDLE;
            cfg_q    <= 16'h0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            addr_q   <= '0;
            lim_m1_q <= '0;
            tmo_q    <= '0;
`ifdef SDRAM_CLR_VERIFY_EN
            err_q    <= 16'h0;
`endif
        end else begin
            state_q  <= state_d;
            cmd_q    <= cmd_d;
            cfg_q    <= cfg_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
            addr_q   <= addr_d;
            lim_m1_q <= lim_m1_d;
            tmo_q    <= tmo_d;
`ifdef SDRAM_CLR_VERIFY_EN
            err_q    <= err_d;
`endif
        end
    end
endmodule

// File: tb/tb_sdram_probe_clear_ctrl.sv
// Bench for sdram_probe_clear_ctrl: aliasing SDRAM model with random busy time, directed scenarios.
module tb_sdram_probe_clear_ctrl;
    localparam int          ADDR_W    = 27;
    localparam int          CLR_WORDS = 64;
    localparam logic [15:0] CLR_VALUE = 16'h0;
    localparam int          TMO_CYC   = 16;
`ifdef SDRAM_CLR_VERIFY_EN
    localparam bit VFY_EN = 1'b1;
`else
    localparam bit VFY_EN = 1'b0;
`endif

    logic              clk_sys = 1'b0;
    logic              RESET   = 1'b1;
    logic              start   = 1'b0;
    logic              sdram_ready;
    logic [15:0]       sdram_dout = 16'h0;
    logic [ADDR_W-1:0] sdram_addr;
    logic [15:0]       sdram_din;
    logic              sdram_we, sdram_rd;
    logic [15:0]       cfg;
    logic              clr_busy, clr_done;
    logic [15:0]       err_cnt;

    int checks   = 0;
    int failures = 0;

    always #5 clk_sys = ~clk_sys;

    sdram_probe_clear_ctrl #(
        .ADDR_W(ADDR_W), .CLR_WORDS(CLR_WORDS), .CLR_VALUE(CLR_VALUE), .TMO_CYC(TMO_CYC)
    ) dut (
        .clk_sys(clk_sys), .RESET(RESET), .start(start), .sdram_ready(sdram_ready),
        .sdram_dout(sdram_dout), .sdram_addr(sdram_addr), .sdram_din(sdram_din),
        .sdram_we(sdram_we), .sdram_rd(sdram_rd), .cfg(cfg), .clr_busy(clr_busy),
        .clr_done(clr_done), .err_cnt(err_cnt)
    );

    // SDRAM model: word memory aliased modulo msize, busy for a random 1..4 cycles per command.
    typedef struct { int addr; logic [15:0] data; } wr_t;
    logic [15:0] mem [int];
    wr_t         wq[$];
    int  msize = 1 << 27;
    bit  nosdram = 1'b0, corrupt = 1'b0, stuck_tb = 1'b1, stuck_on_pw2 = 1'b0, stuck_hw = 1'b0;
    int  busy = 0, cyc = 0, t_pw2 = 0, proto_err = 0;

    assign sdram_ready = (busy == 0) && !stuck_tb && !stuck_hw;

    function automatic logic [15:0] rd_val(input int a);
        int idx;
        logic [15:0] v;
        idx = a % msize;
        v = mem.exists(idx) ? mem[idx] : 16'h0;
        if (corrupt && (idx == 5 || idx == 9)) v = v ^ 16'h1;
        return nosdram ? 16'h0 : v;
    endfunction

    always @(posedge clk_sys) begin
        cyc <= cyc + 1;
        if (!stuck_on_pw2) stuck_hw <= 1'b0;
        if (sdram_we || sdram_rd) begin
            if (!sdram_ready) proto_err <= proto_err + 1;
            busy <= int'($urandom_range(1, 4));
            if (sdram_we) begin
                mem[int'(sdram_addr) % msize] = sdram_din;
                wq.push_back('{int'(sdram_addr), sdram_din});
                if (stuck_on_pw2 && sdram_din == 16'd2064) begin
                    stuck_hw <= 1'b1;
                    t_pw2    <= cyc;
                end
            end else begin
                sdram_dout <= rd_val(int'(sdram_addr));
            end
        end else if (busy > 0) begin
            busy <= busy - 1;
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        checks++;
        assert (obs === exp_v) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp_v);
        end
    endtask

    function automatic logic [15:0] exp_cfg_f(input int sz, input bit nos);
        logic [15:0] c;
        c = 16'h8000;
        if (!nos) c[2:0] = {sz >= (1 << 27), sz >= (1 << 26), sz >= (1 << 25)};
        return c;
    endfunction

    function automatic int exp_lim_f(input int sz, input bit nos);
        int det;
        det = nos ? 0 : (sz >= (1 << 27)) ? (1 << 27) : (sz >= (1 << 26)) ? (1 << 26)
                      : (sz >= (1 << 25)) ? (1 << 25) : 0;
        return (det < CLR_WORDS) ? det : CLR_WORDS;
    endfunction

    task automatic pulse_start();
        @(negedge clk_sys) start = 1'b1;
        @(negedge clk_sys) start = 1'b0;
    endtask

    task automatic wait_done(input string tag);
        int n = 0;
        while (!clr_done && n < 4000) begin
            @(negedge clk_sys);
            n++;
        end
        chk({tag, "_done_in_budget"}, 32'(clr_done), 32'd1);
    endtask

    task automatic check_run(input string tag, input logic [15:0] exp_err);
        int lim, bad_p, bad_c;
        int          pa[4];
        logic [15:0] pd[4];
        pa = '{32'h400_0000, 32'h200_0000, 0, 32'h100_0000};
        pd = '{16'd3128, 16'd2064, 16'd1032, 16'd12345};
        lim   = exp_lim_f(msize, nosdram);
        bad_p = 0;
        bad_c = 0;
        for (int i = 0; i < 4; i++)
            if (i >= wq.size() || wq[i].addr != pa[i] || wq[i].data != pd[i]) bad_p++;
        for (int i = 0; i < lim; i++)
            if (4 + i >= wq.size() || wq[4 + i].addr != i || wq[4 + i].data != CLR_VALUE) bad_c++;
        chk({tag, "_cfg"}, 32'(cfg), 32'(exp_cfg_f(msize, nosdram)));
        chk({tag, "_busy_done_we_rd"}, 32'({clr_busy, clr_done, sdram_we, sdram_rd}), 32'b0100);
        chk({tag, "_write_count"}, 32'(wq.size()), 32'(4 + lim));
        chk({tag, "_probe_writes_bad"}, 32'(bad_p), 32'd0);
        chk({tag, "_clear_writes_bad"}, 32'(bad_c), 32'd0);
        chk({tag, "_err_cnt"}, 32'(err_cnt), 32'(exp_err));
        chk({tag, "_strobe_without_ready"}, 32'(proto_err), 32'd0);
    endtask

    task automatic new_run(input int sz);
        msize = sz;
        mem.delete();
        wq.delete();
    endtask

    initial begin
        int n, diff;
        // Reset with the controller held busy so no auto-start can happen yet.
        repeat (3) @(negedge clk_sys);
        chk("reset_cfg_err", {cfg, err_cnt}, 32'h0);
        chk("reset_addr", 32'(sdram_addr), 32'h0);
        chk("reset_din_flags", {sdram_din, 12'h0, clr_busy, clr_done, sdram_we, sdram_rd}, 32'h0);

        // Auto-start on first ready after reset, full 2^27 part.
        new_run(1 << 27);
        stuck_tb = 1'b0;
        RESET    = 1'b0;
        wait_done("auto_2p27");
        check_run("auto_2p27", 16'h0);

        for (int k = 0; k < 4; k++) begin
            new_run(1 << (24 + int'($urandom_range(0, 3))));
            pulse_start();
            wait_done("rand_size");
            check_run($sformatf("rand_size_%0d", msize), 16'h0);
        end

        // A start pulse during the clear sweep must not restart the sequence.
        new_run(1 << 26);
        pulse_start();
        n = 0;
        while (!clr_busy && n < 2000) begin @(negedge clk_sys); n++; end
        chk("start_busy_reached_clr", 32'(clr_busy), 32'd1);
        pulse_start();
        wait_done("start_while_busy");
        check_run("start_while_busy", 16'h0);

        new_run(1 << 27);
        nosdram = 1'b1;
        pulse_start();
        wait_done("no_sdram");
        check_run("no_sdram", 16'h0);
        nosdram = 1'b0;

        // Controller never returns ready after the second probe write.
        new_run(1 << 27);
        stuck_on_pw2 = 1'b1;
        pulse_start();
        wait_done("timeout");
        diff = cyc - t_pw2;
        chk("timeout_cfg", 32'(cfg), 32'h0000_C000);
        chk("timeout_latency_16_to_20", 32'(diff >= 16 && diff <= 20), 32'd1);
        chk("timeout_busy", 32'(clr_busy), 32'd0);
        stuck_on_pw2 = 1'b0;
        repeat (8) @(negedge clk_sys);
        new_run(1 << 27);
        pulse_start();
        wait_done("after_timeout");
        check_run("after_timeout", 16'h0);

        // RESET in the middle of the clear sweep, then a clean rerun from address 0.
        new_run(1 << 27);
        pulse_start();
        n = 0;
        while (!(clr_busy && sdram_we && sdram_addr == ADDR_W'(20)) && n < 4000) begin
            @(negedge clk_sys);
            n++;
        end
        chk("reached_clr_addr20", 32'(clr_busy && sdram_we && sdram_addr == ADDR_W'(20)), 32'd1);
        RESET = 1'b1;
        @(negedge clk_sys);
        chk("mid_reset_cfg_err", {cfg, err_cnt}, 32'h0);
        chk("mid_reset_addr", 32'(sdram_addr), 32'h0);
        chk("mid_reset_din_flags", {sdram_din, 12'h0, clr_busy, clr_done, sdram_we, sdram_rd}, 32'h0);
        @(negedge clk_sys);
        wq.delete();
        RESET = 1'b0;
        wait_done("rerun_after_reset");
        check_run("rerun_after_reset", 16'h0);

        // Read-back corruption at two cleared words; only counted when verify is built in.
        new_run(1 << 27);
        corrupt = 1'b1;
        pulse_start();
        wait_done("corrupt");
        check_run("corrupt", VFY_EN ? 16'd2 : 16'd0);
        corrupt = 1'b0;

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
